// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter: default widths,
// the hardwired zero register and the arbiter state encoding.
package regfile_port_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PEND   = 3'd1;
  localparam logic [2:0] ST_STALL  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PEND   = ST_PEND,
    STALL  = ST_STALL,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } arb_state_t;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Debug requester <-> arbiter command channel: valid/ready command in,
// one-cycle completion strobe with read (or echoed write) data out.
interface regfile_port_arbiter_if
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              dbg_valid;
  logic              dbg_ready;
  logic              dbg_write;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (
    output dbg_valid, dbg_write, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata
  );

  modport slave (
    input  dbg_valid, dbg_write, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata
  );

endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port and read port A between the pipeline
// (WB write / ID read) and a debug requester; WB writes always win.
// state  | meaning
// IDLE   | ready for a debug command
// PEND   | debug write waiting for a WB gap, starvation counter running
// STALL  | pipeline freeze requested, waiting for stall_ack
// ACCESS | debug command owns the port (a WB write still takes precedence)
// RESP   | one-cycle completion strobe
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wb_reg_write,
  input  logic [ADDR_W-1:0]     i_wb_write_address,
  input  logic [DATA_W-1:0]     i_wb_write_data,
  input  logic [ADDR_W-1:0]     i_id_read_addr_a,
  output logic                  o_stall_req,
  input  logic                  i_stall_ack,
  regfile_port_arbiter_if.slave dbg,
  output logic                  o_rf_reg_write,
  output logic [ADDR_W-1:0]     o_rf_write_address,
  output logic [DATA_W-1:0]     o_rf_write_data,
  output logic [ADDR_W-1:0]     o_rf_read_addr_a,
  input  logic [DATA_W-1:0]     i_rf_data_a
);

  localparam int                CNT_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO   = ADDR_W'(REG_ZERO);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_from_stall;

  logic              w_accept;
  logic              w_starve_inc;
  logic              w_complete;
  logic              w_rf_we;
  logic [ADDR_W-1:0] w_rf_wa;
  logic [DATA_W-1:0] w_rf_wd;
  logic [ADDR_W-1:0] w_rf_ra;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_rdata      <= '0;
      r_from_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd_write  <= dbg.dbg_write;
        r_cmd_addr   <= dbg.dbg_addr;
        r_cmd_wdata  <= dbg.dbg_wdata;
        r_starve_cnt <= '0;
      end else if (w_starve_inc) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
      // Remembers that ACCESS was reached through a freeze, so the freeze is held.
      if (r_state == STALL && i_stall_ack) begin
        r_from_stall <= 1'b1;
      end else if (r_state != ACCESS) begin
        r_from_stall <= 1'b0;
      end
      if (w_complete) begin
        r_rdata <= r_cmd_write ? r_cmd_wdata : i_rf_data_a;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_starve_inc = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (dbg.dbg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = dbg.dbg_write ? PEND : STALL;
        end
      end
      PEND: begin
        if (!i_wb_reg_write) begin
          w_state_nxt = ACCESS;
        end else begin
          w_starve_inc = 1'b1;
          if (r_starve_cnt == STARVE_LAST) begin
            w_state_nxt = STALL;
          end
        end
      end
      STALL: begin
        if (i_stall_ack) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (!r_cmd_write || !i_wb_reg_write) begin
          w_complete  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rf_we = i_wb_reg_write;
    w_rf_wa = i_wb_write_address;
    w_rf_wd = i_wb_write_data;
    w_rf_ra = i_id_read_addr_a;
    if (r_state == ACCESS) begin
      if (r_cmd_write && !i_wb_reg_write) begin
        w_rf_we = 1'b1;
        w_rf_wa = r_cmd_addr;
        w_rf_wd = r_cmd_wdata;
      end else if (!r_cmd_write) begin
        w_rf_ra = r_cmd_addr;
      end
    end
  end

  assign o_rf_reg_write     = w_rf_we && (w_rf_wa != ADDR_ZERO);
  assign o_rf_write_address = w_rf_wa;
  assign o_rf_write_data    = w_rf_wd;
  assign o_rf_read_addr_a   = w_rf_ra;

  assign o_stall_req    = (r_state == STALL) || (r_state == ACCESS && r_from_stall);
  assign dbg.dbg_ready  = (r_state == IDLE);
  assign dbg.dbg_rvalid = (r_state == RESP);
  assign dbg.dbg_rdata  = r_rdata;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed and randomized checks of the register-file port arbiter against
// a register-array reference model kept in the bench.
module tb_regfile_port_arbiter;
  import regfile_port_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_clear = 1'b1;
  logic          wb_reg_write = 1'b0;
  logic [AW-1:0] wb_write_address = '0;
  logic [DW-1:0] wb_write_data = '0;
  logic [AW-1:0] id_read_addr_a = '0;
  logic          stall_req;
  logic          stall_ack = 1'b0;
  logic          rf_reg_write;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic [AW-1:0] rf_read_addr_a;
  logic [DW-1:0] rf_data_a;

  logic [DW-1:0] rf_mem   [32];
  logic [DW-1:0] exp_regs [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) dbg_if ();

  regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_wb_reg_write     (wb_reg_write),
    .i_wb_write_address (wb_write_address),
    .i_wb_write_data    (wb_write_data),
    .i_id_read_addr_a   (id_read_addr_a),
    .o_stall_req        (stall_req),
    .i_stall_ack        (stall_ack),
    .dbg                (dbg_if),
    .o_rf_reg_write     (rf_reg_write),
    .o_rf_write_address (rf_write_address),
    .o_rf_write_data    (rf_write_data),
    .o_rf_read_addr_a   (rf_read_addr_a),
    .i_rf_data_a        (rf_data_a)
  );

  // Register file stand-in: synchronous write, combinational read port A.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_reg_write) begin
      rf_mem[rf_write_address] <= rf_write_data;
    end
  end
  assign rf_data_a = rf_mem[rf_read_addr_a];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_reg_write     = en;
    wb_write_address = a;
    wb_write_data    = d;
    if (en && a != 0) exp_regs[a] = d;
  endtask

  task automatic dbg_set(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_if.dbg_valid = v;
    dbg_if.dbg_write = w;
    dbg_if.dbg_addr  = a;
    dbg_if.dbg_wdata = d;
  endtask

  task automatic chk_wb(input string tag);
    if (wb_reg_write) begin
      chk({tag, "_we"}, rf_reg_write, (wb_write_address != 0));
      chk({tag, "_wa"}, rf_write_address, wb_write_address);
      chk({tag, "_wd"}, rf_write_data, wb_write_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          seen;
    logic          op_w;
    logic          got;
    logic [AW-1:0] op_a;
    logic [DW-1:0] op_d;
    int            busy_pct;
    int            ack_dly;
    int            waited;
    int            cyc;

    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    dbg_set(1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    chk("rst_ready", dbg_if.dbg_ready, 1'b1);
    chk("rst_rvalid", dbg_if.dbg_rvalid, 1'b0);
    chk("rst_rdata", dbg_if.dbg_rdata, '0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_rf_we", rf_reg_write, 1'b0);
    rst_n = 1'b1;
    mem_clear = 1'b0;

    // Reset in the middle of a stalled read
    dbg_set(1'b1, 1'b0, 5'd1, '0);
    #1 chk("t1_ready", dbg_if.dbg_ready, 1'b1);
    tick();
    dbg_set(1'b0, 1'b0, '0, '0);
    #1 chk("t1_stall", stall_req, 1'b1);
    chk("t1_busy", dbg_if.dbg_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t1_rst_stall", stall_req, 1'b0);
    chk("t1_rst_rvalid", dbg_if.dbg_rvalid, 1'b0);
    chk("t1_rst_ready", dbg_if.dbg_ready, 1'b1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (dbg_if.dbg_rvalid) seen = 1'b1;
    end
    chk("t1_no_rvalid", seen, 1'b0);

    // Debug write with WB idle
    dbg_set(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("t2_ready", dbg_if.dbg_ready, 1'b1);
    tick();
    dbg_set(1'b0, 1'b0, '0, '0);
    #1 chk("t2_pend_we", rf_reg_write, 1'b0);
    chk("t2_pend_stall", stall_req, 1'b0);
    tick();
    chk("t2_acc_we", rf_reg_write, 1'b1);
    chk("t2_acc_wa", rf_write_address, 5'd5);
    chk("t2_acc_wd", rf_write_data, 32'hDEADBEEF);
    chk("t2_acc_stall", stall_req, 1'b0);
    tick();
    chk("t2_rvalid", dbg_if.dbg_rvalid, 1'b1);
    chk("t2_rdata", dbg_if.dbg_rdata, 32'hDEADBEEF);
    chk("t2_resp_stall", stall_req, 1'b0);
    exp_regs[5] = 32'hDEADBEEF;
    tick();
    chk("t2_rvalid_pulse", dbg_if.dbg_rvalid, 1'b0);
    chk("t2_ready_again", dbg_if.dbg_ready, 1'b1);
    chk("t2_r5", rf_mem[5], 32'hDEADBEEF);

    // Debug write starved by continuous WB traffic
    dbg_set(1'b1, 1'b1, 5'd7, 32'hA5A50007);
    wb_set(1'b1, 5'd16, $urandom);
    tick();
    dbg_set(1'b0, 1'b0, '0, '0);
    seen = 1'b0;
    for (int c = 1; c <= SL; c++) begin
      wb_set(1'b1, AW'(16 + c), $urandom);
      #1 chk_wb("t3_pend");
      if (stall_req) seen = 1'b1;
      tick();
    end
    chk("t3_no_early_stall", seen, 1'b0);
    wb_set(1'b1, 5'd25, $urandom);
    #1 chk("t3_stall_rise", stall_req, 1'b1);
    chk_wb("t3_stall");
    tick();
    stall_ack = 1'b1;
    wb_set(1'b0, '0, '0);
    #1 chk("t3_ack_we", rf_reg_write, 1'b0);
    tick();
    chk("t3_acc_we", rf_reg_write, 1'b1);
    chk("t3_acc_wa", rf_write_address, 5'd7);
    chk("t3_acc_wd", rf_write_data, 32'hA5A50007);
    chk("t3_acc_stall", stall_req, 1'b1);
    exp_regs[7] = 32'hA5A50007;
    tick();
    stall_ack = 1'b0;
    #1 chk("t3_rvalid", dbg_if.dbg_rvalid, 1'b1);
    chk("t3_rdata", dbg_if.dbg_rdata, 32'hA5A50007);
    chk("t3_resp_stall", stall_req, 1'b0);
    tick();

    // Debug read of a WB-preloaded register, ack two cycles after the request
    wb_set(1'b1, 5'd9, 32'h00001234);
    tick();
    wb_set(1'b0, '0, '0);
    id_read_addr_a = 5'd3;
    dbg_set(1'b1, 1'b0, 5'd9, '0);
    #1 chk("t4_id_passthru", rf_read_addr_a, 5'd3);
    tick();
    dbg_set(1'b0, 1'b0, '0, '0);
    #1 chk("t4_stall", stall_req, 1'b1);
    tick();
    tick();
    stall_ack = 1'b1;
    tick();
    chk("t4_acc_raddr", rf_read_addr_a, 5'd9);
    chk("t4_acc_stall", stall_req, 1'b1);
    tick();
    stall_ack = 1'b0;
    #1 chk("t4_rvalid", dbg_if.dbg_rvalid, 1'b1);
    chk("t4_rdata", dbg_if.dbg_rdata, 32'h00001234);
    tick();

    // Debug write to r0, then a WB write to r0
    dbg_set(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
    seen = 1'b0;
    tick();
    dbg_set(1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= 3; c++) begin
      #1 if (rf_reg_write) seen = 1'b1;
      if (c == 3) begin
        chk("t5_rvalid", dbg_if.dbg_rvalid, 1'b1);
        chk("t5_rdata", dbg_if.dbg_rdata, 32'hFFFFFFFF);
      end
      tick();
    end
    chk("t5_no_we", seen, 1'b0);
    wb_set(1'b1, 5'd0, 32'h0000CAFE);
    #1 chk("t5_wb_r0_we", rf_reg_write, 1'b0);
    tick();
    wb_set(1'b0, '0, '0);
    chk("t5_r0", rf_mem[0], '0);

    // WB and debug write collide on r3 in ACCESS
    dbg_set(1'b1, 1'b1, 5'd3, 32'h00000022);
    tick();
    dbg_set(1'b0, 1'b0, '0, '0);
    tick();
    wb_set(1'b1, 5'd3, 32'h00000011);
    #1 chk("t6_wb_we", rf_reg_write, 1'b1);
    chk("t6_wb_wa", rf_write_address, 5'd3);
    chk("t6_wb_wd", rf_write_data, 32'h00000011);
    chk("t6_wb_rvalid", dbg_if.dbg_rvalid, 1'b0);
    tick();
    wb_set(1'b0, '0, '0);
    #1 chk("t6_dbg_we", rf_reg_write, 1'b1);
    chk("t6_dbg_wa", rf_write_address, 5'd3);
    chk("t6_dbg_wd", rf_write_data, 32'h00000022);
    exp_regs[3] = 32'h00000022;
    tick();
    chk("t6_rvalid", dbg_if.dbg_rvalid, 1'b1);
    tick();
    chk("t6_r3", rf_mem[3], 32'h00000022);

    // Randomized debug traffic against random WB activity and ack delays
    for (int op = 0; op < 40; op++) begin
      op_w     = 1'($urandom_range(0, 1));
      op_a     = AW'($urandom_range(0, 15));
      op_d     = $urandom;
      busy_pct = (op % 4 == 0) ? 90 : 40;
      ack_dly  = $urandom_range(0, 3);
      dbg_set(1'b1, op_w, op_a, op_d);
      wb_set(1'($urandom_range(0, 99) < busy_pct), AW'($urandom_range(16, 31)), $urandom);
      #1 chk("rnd_issue_ready", dbg_if.dbg_ready, 1'b1);
      chk("rnd_rvalid_pulse", dbg_if.dbg_rvalid, 1'b0);
      chk_wb("rnd_issue");
      tick();
      got = 1'b0;
      cyc = 0;
      waited = 0;
      while (!got && cyc < 300) begin
        if (stall_req) begin
          if (waited >= ack_dly) stall_ack = 1'b1;
          waited++;
        end else begin
          stall_ack = 1'b0;
          waited = 0;
        end
        if (stall_ack) wb_set(1'b0, '0, '0);
        else wb_set(1'($urandom_range(0, 99) < busy_pct), AW'($urandom_range(16, 31)), $urandom);
        dbg_set(1'b1, 1'b1, 5'd1, 32'hBAD00000);
        #1 chk_wb("rnd_wb");
        chk("rnd_busy_ready", dbg_if.dbg_ready, 1'b0);
        if (dbg_if.dbg_rvalid) begin
          got = 1'b1;
          chk("rnd_rdata", dbg_if.dbg_rdata, op_w ? op_d : exp_regs[op_a]);
          if (op_w && op_a != 0) exp_regs[op_a] = op_d;
        end
        tick();
        cyc++;
      end
      chk("rnd_done", got, 1'b1);
    end
    dbg_set(1'b0, 1'b0, '0, '0);
    wb_set(1'b0, '0, '0);
    stall_ack = 1'b0;
    tick();
    tick();

    for (int i = 0; i < 32; i++) begin
      chk($sformatf("final_r%0d", i), rf_mem[i], exp_regs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
